// File: rtl/imager_pixel_packer.sv
// N-channel pixel packer: each camera packs pixels little-endian into bus words,
// buffers them in its own FIFO, and shares one registered read port.
module imager_pixel_packer #(
  parameter int NUM_CAMS     = 2,
  parameter int PIXEL_WIDTH  = 8,
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH        = 256,
  parameter int AFULL_THRESH = 192,
  localparam int SEL_W = (NUM_CAMS > 1) ? $clog2(NUM_CAMS) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CAMS-1:0]             cam_reset,
  input  logic [NUM_CAMS-1:0]             pix_valid,
  input  logic [NUM_CAMS*PIXEL_WIDTH-1:0] pix_data,
  input  logic [NUM_CAMS-1:0]             frame_done,
  input  logic [NUM_CAMS-1:0]             ovf_clear,
  input  logic [SEL_W-1:0]                rd_sel,
  input  logic                            rd_en,
  output logic [WORD_WIDTH-1:0]           rd_data,
  output logic                            rd_valid,
  output logic [NUM_CAMS-1:0]             fifo_empty,
  output logic [NUM_CAMS-1:0]             fifo_afull,
  output logic [NUM_CAMS-1:0]             fifo_full,
  output logic [NUM_CAMS-1:0]             fifo_overflow,
  output logic [NUM_CAMS*CNT_W-1:0]       word_count
);

  localparam int LANES  = WORD_WIDTH / PIXEL_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  AFULL_C   = CNT_W'(AFULL_THRESH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  logic [NUM_CAMS-1:0]            pop;
  logic [NUM_CAMS*WORD_WIDTH-1:0] dout_all;
  logic                           rd_valid_q;
  logic [SEL_W-1:0]               rd_ch_q;

  for (genvar gi = 0; gi < NUM_CAMS; gi++) begin : g_ch
    logic [LANE_W-1:0]      lane_q, lane_d;
    logic [WORD_WIDTH-1:0]  word_q, word_d, packed_w;
    logic                   stage_vld_q, stage_vld_d;
    logic [WORD_WIDTH-1:0]  stage_q, stage_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   empty_q, afull_q, full_q;
    logic                   push_ok, drop, filled;
    logic [PIXEL_WIDTH-1:0] pix;
    logic [WORD_WIDTH-1:0]  dout_q;
    logic [WORD_WIDTH-1:0]  mem [DEPTH];

    assign pix     = pix_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign pop[gi] = rd_en && (rd_sel == SEL_W'(gi)) && (count_q != '0) && !cam_reset[gi];
    // A full FIFO still accepts the staged word when the same edge pops it.
    assign push_ok = stage_vld_q && ((count_q != DEPTH_C) || pop[gi]);
    assign drop    = stage_vld_q && !push_ok;
    assign count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop[gi]);
    assign ovf_d   = drop | (ovf_q & ~ovf_clear[gi]);

    always_comb begin
      packed_w    = word_q;
      filled      = 1'b0;
      lane_d      = lane_q;
      word_d      = word_q;
      stage_vld_d = 1'b0;
      stage_d     = stage_q;
      if (pix_valid[gi]) begin
        packed_w[lane_q*PIXEL_WIDTH +: PIXEL_WIDTH] = pix;
        filled = (lane_q == LAST_LANE);
        lane_d = lane_q + 1'b1;
        word_d = packed_w;
      end
      // Word register is zeroed on staging so a later flush zero-fills upper lanes.
      if (filled || (frame_done[gi] && (lane_d != '0))) begin
        stage_vld_d = 1'b1;
        stage_d     = packed_w;
        lane_d      = '0;
        word_d      = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset || cam_reset[gi]) begin
        lane_q      <= '0;
        word_q      <= '0;
        stage_vld_q <= 1'b0;
        stage_q     <= '0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
        ovf_q       <= 1'b0;
        empty_q     <= 1'b1;
        afull_q     <= 1'b0;
        full_q      <= 1'b0;
      end else begin
        lane_q      <= lane_d;
        word_q      <= word_d;
        stage_vld_q <= stage_vld_d;
        stage_q     <= stage_d;
        wr_ptr_q    <= wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_q    <= rd_ptr_q + PTR_W'(pop[gi]);
        count_q     <= count_d;
        ovf_q       <= ovf_d;
        empty_q     <= (count_d == '0);
        afull_q     <= (count_d >= AFULL_C);
        full_q      <= (count_d == DEPTH_C);
      end
    end

    always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= stage_q;
    end

    always_ff @(posedge clk) begin
      if (reset) dout_q <= '0;
      else if (pop[gi]) dout_q <= mem[rd_ptr_q];
    end

    assign dout_all[gi*WORD_WIDTH +: WORD_WIDTH] = dout_q;
    assign fifo_empty[gi]    = empty_q;
    assign fifo_afull[gi]    = afull_q;
    assign fifo_full[gi]     = full_q;
    assign fifo_overflow[gi] = ovf_q;
    assign word_count[gi*CNT_W +: CNT_W] = count_q;
  end

  // Output word comes from the channel that last popped, so it holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_ch_q    <= '0;
    end else begin
      rd_valid_q <= |pop;
      for (int i = 0; i < NUM_CAMS; i++) begin
        if (pop[i]) rd_ch_q <= SEL_W'(i);
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = dout_all[rd_ch_q*WORD_WIDTH +: WORD_WIDTH];

endmodule

// File: tb/tb_imager_pixel_packer.sv
// Directed bench for imager_pixel_packer with per-channel expected-word queues.
module tb_imager_pixel_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cam_reset, pix_valid, frame_done, ovf_clear;
  logic [15:0] pix_data;
  logic [0:0]  rd_sel;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [1:0]  fifo_empty, fifo_afull, fifo_full, fifo_overflow;
  logic [17:0] word_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] last_rd = 32'h0;

  imager_pixel_packer dut (
    .clk(clk), .reset(reset), .cam_reset(cam_reset), .pix_valid(pix_valid),
    .pix_data(pix_data), .frame_done(frame_done), .ovf_clear(ovf_clear),
    .rd_sel(rd_sel), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_empty(fifo_empty), .fifo_afull(fifo_afull), .fifo_full(fifo_full),
    .fifo_overflow(fifo_overflow), .word_count(word_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_read(input logic sel);
    logic [31:0] e;
    logic        has;
    has = sel ? (q1.size() > 0) : (q0.size() > 0);
    if (has) begin
      if (sel) e = q1.pop_front();
      else     e = q0.pop_front();
      chk("rd_valid", {31'b0, rd_valid}, 32'd1);
      chk("rd_data", rd_data, e);
      last_rd = e;
    end else begin
      chk("rd_valid_empty", {31'b0, rd_valid}, 32'd0);
      chk("rd_data_hold", rd_data, last_rd);
    end
    $display("read ch%0d data=%08h valid=%0b", sel, rd_data, rd_valid);
  endtask

  task automatic cyc(input logic [1:0] pv, input logic [7:0] p0, input logic [7:0] p1,
                     input logic [1:0] fd, input logic re, input logic sel);
    pix_valid = pv; pix_data = {p1, p0}; frame_done = fd; rd_en = re; rd_sel = sel;
    @(posedge clk); #1;
    pix_valid = '0; frame_done = '0; rd_en = 1'b0;
    if (re) check_read(sel);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic put_word(input int ch, input logic [31:0] w, input logic record);
    for (int l = 0; l < 4; l++)
      cyc((ch == 1) ? 2'b10 : 2'b01, w[l*8 +: 8], w[l*8 +: 8], 2'b00, 1'b0, 1'b0);
    if (record) begin
      if (ch == 1) q1.push_back(w);
      else         q0.push_back(w);
    end
    $display("push ch%0d word=%08h recorded=%0b", ch, w, record);
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return {23'b0, word_count[ch*9 +: 9]};
  endfunction

  initial begin
    logic [31:0] w0, w1;
    reset = 1'b1; cam_reset = '0; pix_valid = '0; frame_done = '0; ovf_clear = '0;
    pix_data = '0; rd_sel = '0; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_empty", {30'b0, fifo_empty}, 32'd3);
    chk("rst_afull", {30'b0, fifo_afull}, 32'd0);
    chk("rst_full", {30'b0, fifo_full}, 32'd0);
    chk("rst_ovf", {30'b0, fifo_overflow}, 32'd0);
    chk("rst_count", {14'b0, word_count}, 32'd0);
    reset = 1'b0;

    // Eight back-to-back pixels on ch0; word lands one edge after its last pixel.
    for (int i = 0; i < 8; i++) begin
      cyc(2'b01, 8'(i + 1), 8'h0, 2'b00, 1'b0, 1'b0);
      if (i == 3) begin
        chk("lat_cnt_before", cnt(0), 32'd0);
        chk("lat_empty_before", {31'b0, fifo_empty[0]}, 32'd1);
        q0.push_back(32'h04030201);
      end
      if (i == 4) begin
        chk("lat_cnt_after", cnt(0), 32'd1);
        chk("lat_empty_after", {31'b0, fifo_empty[0]}, 32'd0);
      end
    end
    q0.push_back(32'h08070605);
    idle(1);
    chk("ch0_cnt2", cnt(0), 32'd2);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    chk("ch0_empty_after_reads", {31'b0, fifo_empty[0]}, 32'd1);
    chk("ch1_untouched_cnt", cnt(1), 32'd0);
    chk("ch1_untouched_empty", {31'b0, fifo_empty[1]}, 32'd1);

    // Partial-word flush, idle flush, and flush coinciding with the completing pixel.
    cyc(2'b10, 8'h0, 8'hAA, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 8'h0, 8'hBB, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 8'h0, 8'h00, 2'b10, 1'b0, 1'b0);
    q1.push_back(32'h0000BBAA);
    idle(1);
    chk("flush_cnt", cnt(1), 32'd1);
    cyc(2'b00, 8'h0, 8'h00, 2'b10, 1'b0, 1'b0);
    idle(1);
    chk("flush_lane0_cnt", cnt(1), 32'd1);
    cyc(2'b10, 8'h0, 8'h11, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 8'h0, 8'h22, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 8'h0, 8'h33, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 8'h0, 8'h44, 2'b10, 1'b0, 1'b0);
    q1.push_back(32'h44332211);
    idle(2);
    chk("flush_full_word_cnt", cnt(1), 32'd2);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b1);

    // Fill ch0 to DEPTH, checking the afull and full thresholds.
    for (int j = 0; j < 256; j++) begin
      put_word(0, 32'hC0DE0000 | 32'(j), 1'b1);
      idle(1);
      if (j == 190) chk("afull_191", {31'b0, fifo_afull[0]}, 32'd0);
      if (j == 191) begin
        chk("afull_192", {31'b0, fifo_afull[0]}, 32'd1);
        chk("full_192", {31'b0, fifo_full[0]}, 32'd0);
      end
      if (j == 254) chk("full_255", {31'b0, fifo_full[0]}, 32'd0);
      if (j == 255) begin
        chk("full_256", {31'b0, fifo_full[0]}, 32'd1);
        chk("cnt_256", cnt(0), 32'd256);
      end
    end
    put_word(0, 32'hDEADBEEF, 1'b0);
    idle(1);
    chk("ovf_set", {31'b0, fifo_overflow[0]}, 32'd1);
    chk("ovf_cnt", cnt(0), 32'd256);
    idle(3);
    chk("ovf_sticky", {31'b0, fifo_overflow[0]}, 32'd1);
    chk("ovf_ch1_clear", {31'b0, fifo_overflow[1]}, 32'd0);
    ovf_clear = 2'b01;
    idle(1);
    ovf_clear = 2'b00;
    chk("ovf_cleared", {31'b0, fifo_overflow[0]}, 32'd0);

    // Push into a full FIFO on the same edge as a pop of that channel.
    w0 = 32'h5A5A0001;
    for (int l = 0; l < 4; l++) cyc(2'b01, w0[l*8 +: 8], 8'h0, 2'b00, 1'b0, 1'b0);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    q0.push_back(w0);
    chk("fullpop_cnt", cnt(0), 32'd256);
    chk("fullpop_ovf", {31'b0, fifo_overflow[0]}, 32'd0);
    chk("fullpop_full", {31'b0, fifo_full[0]}, 32'd1);

    repeat (256) cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    chk("drain_empty", {31'b0, fifo_empty[0]}, 32'd1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);

    // Both channels streaming with interleaved reads.
    for (int j = 0; j < 4; j++) begin
      w0 = 32'hA0A00000 + 32'(j);
      w1 = 32'hB1B10000 + 32'(j);
      for (int l = 0; l < 4; l++)
        cyc(2'b11, w0[l*8 +: 8], w1[l*8 +: 8], 2'b00,
            (j > 0) && (l == 1 || l == 3), (l == 3));
      q0.push_back(w0);
      q1.push_back(w1);
    end
    idle(1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b1);

    // Per-channel clear mid-word with a coincident read of the same channel.
    put_word(0, 32'h11112222, 1'b1);
    put_word(0, 32'h33334444, 1'b1);
    for (int j = 0; j < 3; j++) put_word(1, 32'h99990000 + 32'(j), 1'b1);
    cyc(2'b10, 8'h0, 8'h77, 2'b00, 1'b0, 1'b0);
    cyc(2'b10, 8'h0, 8'h88, 2'b00, 1'b0, 1'b0);
    chk("pre_clr_cnt1", cnt(1), 32'd3);
    cam_reset = 2'b10; rd_en = 1'b1; rd_sel = 1'b1;
    @(posedge clk); #1;
    cam_reset = 2'b00; rd_en = 1'b0;
    q1.delete();
    $display("cam_reset ch1");
    chk("clr_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("clr_cnt1", cnt(1), 32'd0);
    chk("clr_empty1", {31'b0, fifo_empty[1]}, 32'd1);
    chk("clr_cnt0", cnt(0), 32'd2);
    put_word(1, 32'h04030201, 1'b1);
    idle(1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b1);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    cyc(2'b00, 8'h0, 8'h0, 2'b00, 1'b1, 1'b0);
    chk("final_empty", {30'b0, fifo_empty}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imager_pixel_packer.md
Name: imager_pixel_packer

Overview:
- Parametrised N-camera pixel buffering stage between the per-camera ADC controllers and the APB interface.
- Replaces the single-camera byte FIFO. Each channel packs a pixel stream into bus-width words and holds them in its own FIFO.
- Adds per-channel flags, per-channel clear, sticky overflow and an end-of-frame flush of partial words.
- A single shared read port, with a channel select, serves the APB interface.

Parameters:
- NUM_CAMS, 2, number of camera channels (1..4).
- PIXEL_WIDTH, 8, bits per pixel sample.
- WORD_WIDTH, 32, FIFO word width. Must be an integer multiple of PIXEL_WIDTH. LANES = WORD_WIDTH/PIXEL_WIDTH.
- DEPTH, 256, words per channel FIFO. Must be a power of 2.
- AFULL_THRESH, 192, word count at or above which fifo_afull asserts.
- Derived: SEL_W = max(1, clog2(NUM_CAMS)); CNT_W = clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high, clears all channels
- cam_reset  in  NUM_CAMS  per-channel synchronous clear
- pix_valid  in  NUM_CAMS  pixel strobe from each ADC controller
- pix_data  in  NUM_CAMS*PIXEL_WIDTH  pixel data; channel i occupies bits [i*PIXEL_WIDTH +: PIXEL_WIDTH]
- frame_done  in  NUM_CAMS  end-of-frame pulse; flushes any partial word
- ovf_clear  in  NUM_CAMS  clears the sticky overflow flag
- rd_sel  in  SEL_W  channel to read
- rd_en  in  1  read strobe
- rd_data  out  WORD_WIDTH  read word
- rd_valid  out  1  rd_data valid this cycle
- fifo_empty  out  NUM_CAMS  per-channel empty
- fifo_afull  out  NUM_CAMS  per-channel count >= AFULL_THRESH
- fifo_full  out  NUM_CAMS  per-channel count == DEPTH; used as ADC backpressure
- fifo_overflow  out  NUM_CAMS  sticky: a word was dropped
- word_count  out  NUM_CAMS*CNT_W  per-channel occupancy

Behaviour:
- Reset values: rd_data=0, rd_valid=0, fifo_empty=all 1, every other output 0. Packers, pointers and counts are all cleared.
- Packer (per channel):
  - Holds a lane counter (0..LANES-1) and a word register.
  - Lane order is little-endian: the first pixel goes to bits [PIXEL_WIDTH-1:0].
  - On pix_valid the pixel is written into the current lane and the lane counter increments.
  - When the last lane is filled, the word moves into a one-entry staging register and the lane counter wraps to 0.
  - The staging register pushes to the FIFO on the next edge. Latency: last pixel sampled at edge k gives the word in the FIFO (count+1, empty=0) after edge k+1.
  - Packing continues without stall across words.
- Flush:
  - frame_done with lane counter != 0 stages the partial word with unused upper lanes zero-filled, then resets the lane counter.
  - A pix_valid in the same cycle is packed first. If that pixel completes the word, exactly one word is staged; there is no extra empty word.
  - frame_done with lane counter 0 and no pix_valid does nothing.
- Push:
  - A push is accepted if the FIFO is not full, or if a pop from the same channel occurs in the same cycle (count unchanged).
  - Otherwise the word is dropped and fifo_overflow is set.
- Overflow flag:
  - Cleared only by reset, cam_reset or ovf_clear.
  - If ovf_clear coincides with a new drop, set wins.
- Read port:
  - rd_en sampled at edge k with channel rd_sel not empty: rd_data = FIFO head and rd_valid=1 during cycle k+1. The read pointer advances and the count decrements at edge k.
  - rd_valid is a one-cycle pulse. Back-to-back rd_en reads consecutive words.
  - rd_en on an empty channel: rd_valid=0, rd_data holds, no pointer change.
  - rd_sel >= NUM_CAMS is treated as empty.
- Flag timing: fifo_empty, fifo_afull, fifo_full and word_count are registered from count and update on the same edge as the push or pop.
- Pointers: binary with wrap at DEPTH. Count is a separate CNT_W register.
- Channel clear:
  - cam_reset[i] clears the packer, staging register, pointers, count and overflow of channel i only. It overrides any same-cycle pixel, flush or read on i.
  - A read of i in that cycle returns rd_valid=0.
  - Other channels are unaffected.
- Storage: one inferred synchronous-read RAM per channel. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then 8 pixels 0x01..0x08 on ch0. Read ch0 twice -> 0x04030201, then 0x08070605. Then fifo_empty[0]=1 and ch1 stays untouched.
- ch1 gets pixels 0xAA,0xBB, then frame_done -> one word 0x0000BBAA, word_count[1]=1. frame_done with lane 0 -> count unchanged.
- Fill ch0 to DEPTH words -> fifo_afull asserts at 192 and fifo_full at 256. One more word -> dropped, fifo_overflow[0]=1 (sticky). ovf_clear[0] -> 0.
- Full ch0 with a push and rd_en in the same cycle -> rd_valid=1, push accepted, count stays 256, overflow stays 0.
- ch0 and ch1 streaming concurrently with interleaved reads via rd_sel -> each channel's word sequence intact. rd_en on an empty channel -> rd_valid=0.
- cam_reset[1] mid-word with 3 words queued -> ch1 count 0, empty=1, partial word discarded. ch0 data and count unchanged.
